// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand-request and result handshake bundle for the nibble-serial add/subtract sequencer.
// The master side issues operands and consumes results; the slave side is the sequencer.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, op_a, op_b, op_sub, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract sequencer that time-multiplexes one external 4-bit ripple-carry slice,
// LSB nibble first, chaining the carry through an internal register.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  nibble_serial_add_ctrl_if.slave bus,
  output logic [3:0]              add_a,
  output logic [3:0]              add_b,
  output logic                    add_cin,
  input  logic [3:0]              add_sum,
  input  logic                    add_cout
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] beff_q;
  logic [WIDTH-1:0] res;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             ovf_q;

  logic [WIDTH-1:0] beff_in;
  logic             cin_in;

  assign beff_in = bus.op_sub ? ~bus.op_b : bus.op_b;
  assign cin_in  = bus.op_sub ? 1'b1 : bus.c_in;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = res;
  assign bus.c_out     = carry;
  assign bus.ovf       = ovf_q;

  // Adder drive is registered one step ahead: the nibble for index idx is
  // loaded at the edge that moves idx there, so it is valid throughout RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      beff_q      <= '0;
      res         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      add_a       <= '0;
      add_b       <= '0;
      add_cin     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.op_a;
            beff_q     <= beff_in;
            carry      <= cin_in;
            idx        <= '0;
            add_a      <= bus.op_a[3:0];
            add_b      <= beff_in[3:0];
            add_cin    <= cin_in;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          res[4*idx +: 4] <= add_sum;
          carry           <= add_cout;
          if (idx == IW'(NIB - 1)) begin
            // Final nibble's sum MSB comes straight from the adder this cycle.
            ovf_q       <= (a_q[WIDTH-1] == beff_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            add_a       <= '0;
            add_b       <= '0;
            add_cin     <= 1'b0;
            state       <= DONE;
          end else begin
            idx     <= idx + 1'b1;
            add_a   <= a_q[4*(32'(idx) + 1) +: 4];
            add_b   <= beff_q[4*(32'(idx) + 1) +: 4];
            add_cin <= add_cout;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed-vector bench for nibble_serial_add_ctrl at WIDTH=16 with a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;
  logic       clk;
  logic       rst;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_sum;
  logic       add_cout;

  int vec;
  int errs;

  nibble_serial_add_ctrl_if #(.WIDTH(16)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    vec++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    vec++; if (bus.sum !== 16'h0000) begin errs++; $display("FAIL reset_sum got=%h exp=0000", bus.sum); end
    vec++; if (bus.c_out !== 1'b0 || bus.ovf !== 1'b0) begin errs++; $display("FAIL reset_flags got c_out=%b ovf=%b exp 0 0", bus.c_out, bus.ovf); end
    vec++; if ({add_a, add_b, add_cin} !== 9'h000) begin errs++; $display("FAIL reset_adder got a=%h b=%h cin=%b exp 0", add_a, add_b, add_cin); end
  endtask

  // cins: bit k is the expected add_cin while nibble k is on the adder.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin, input logic [3:0] cins,
                        input logic [15:0] es, input logic ec, input logic eo, input logic tog);
    bus.op_a = a; bus.op_b = b; bus.op_sub = sub; bus.c_in = cin;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec++; if (add_a !== a[4*k +: 4]) begin errs++; $display("FAIL %s add_a[%0d] got=%h exp=%h", nm, k, add_a, a[4*k +: 4]); end
      vec++; if (add_cin !== cins[k]) begin errs++; $display("FAIL %s add_cin[%0d] got=%b exp=%b", nm, k, add_cin, cins[k]); end
      vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errs++; $display("FAIL %s run_hs[%0d] got out_valid=%b in_ready=%b exp 0 0", nm, k, bus.out_valid, bus.in_ready); end
      if (tog) bus.c_in = ~bus.c_in;
      step();
    end
    vec++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL %s out_valid got=%b exp=1", nm, bus.out_valid); end
    vec++; if (bus.sum !== es) begin errs++; $display("FAIL %s sum got=%h exp=%h", nm, bus.sum, es); end
    vec++; if (bus.c_out !== ec) begin errs++; $display("FAIL %s c_out got=%b exp=%b", nm, bus.c_out, ec); end
    vec++; if (bus.ovf !== eo) begin errs++; $display("FAIL %s ovf got=%b exp=%b", nm, bus.ovf, eo); end
    vec++; if ({add_a, add_b, add_cin} !== 9'h000) begin errs++; $display("FAIL %s adder_idle got a=%h b=%h cin=%b exp 0", nm, add_a, add_b, add_cin); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errs++; $display("FAIL %s release got out_valid=%b in_ready=%b exp 0 1", nm, bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_add();
    run_op("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 4'b1110, 16'h2233, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_carry_in();
    run_op("wrap", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 4'b1111, 16'h0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_subtract();
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b0, 4'b0001, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b0, 4'b1111, 16'h0002, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'b1110, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 4'b0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("no_ovf",  16'h4000, 16'h1000, 1'b0, 1'b0, 4'b0000, 16'h5000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    bus.op_a = 16'h1111; bus.op_b = 16'h2222; bus.op_sub = 1'b0; bus.c_in = 1'b0;
    bus.in_valid = 1'b1;
    step();
    // Keep requesting a different operation; it must never be taken.
    bus.op_a = 16'hAAAA; bus.op_b = 16'h0001;
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      vec++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errs++; $display("FAIL bp_hold_hs[%0d] got out_valid=%b in_ready=%b exp 1 0", i, bus.out_valid, bus.in_ready); end
      vec++; if (bus.sum !== 16'h3333 || bus.c_out !== 1'b0 || bus.ovf !== 1'b0) begin errs++; $display("FAIL bp_hold_data[%0d] got sum=%h c_out=%b ovf=%b exp 3333 0 0", i, bus.sum, bus.c_out, bus.ovf); end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1 0", bus.in_ready, bus.out_valid); end
    step();
    vec++; if (bus.in_ready !== 1'b1 || add_a !== 4'h0) begin errs++; $display("FAIL bp_no_accept got in_ready=%b add_a=%h exp 1 0", bus.in_ready, add_a); end
  endtask

  task automatic test_reset_mid_op();
    bus.op_a = 16'h1234; bus.op_b = 16'h0FFF; bus.op_sub = 1'b0; bus.c_in = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    vec++; if (add_a !== 4'h2) begin errs++; $display("FAIL mid_pre_reset add_a got=%h exp=2", add_a); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL mid_reset_hs got in_ready=%b out_valid=%b exp 1 0", bus.in_ready, bus.out_valid); end
    vec++; if (add_a !== 4'h0 || bus.sum !== 16'h0000) begin errs++; $display("FAIL mid_reset_data got add_a=%h sum=%h exp 0 0000", add_a, bus.sum); end
    repeat (3) step();
    vec++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL mid_reset_discard got out_valid=%b exp 0", bus.out_valid); end
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 4'b0000, 16'h0002, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vec = 0;
    errs = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.op_sub = 1'b0;
    bus.c_in = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_wrap_carry_in();
    test_subtract();
    test_overflow();
    test_backpressure();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
